fetch_ifid: RTL and testbench

- Upstream neighbour of the main decoder in the pipelined LEGv8 core.
- Holds the program counter and drives the instruction-memory address (imem read is combinational).
- Captures the fetched word into the IF/ID pipeline register, and exposes the 11-bit opcode field directly to the decoder's Op input.
- Supports stall (load-use hazard) and flush (taken branch); a flush inserts an all-zero bubble, which the decoder maps to its default all-zero control word.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pipe_reg.sv | 36 +++
 rtl/fetch_ifid.sv | 83 ++++++++
 tb/tb_fetch_ifid.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the fetch stage and IF/ID register.
//   NOP_INSTR      bubble word written into IF/ID on a flush
//   OP_MSB/OP_LSB  opcode field bounds inside a 32-bit LEGv8 word
//   OP_W           opcode field width
//   PC_INCR        sequential PC step (one 32-bit instruction)
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          OP_MSB    = 31;
  localparam int          OP_LSB    = 21;
  localparam int          OP_W      = OP_MSB - OP_LSB + 1;
  localparam int          PC_INCR   = 4;

  // Word-aligned redirect target: the low two address bits are dropped.
  function automatic logic [63:0] align_word(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: W-bit pipeline flop.
//   clk     rising-edge clock
//   reset   synchronous active-high reset, loads RST_VAL
//   en_i    load d_i
//   clr_i   synchronous clear to zero; beats en_i
//   d_i     next value
//   q_o     registered value
// Priority per edge: reset > clear > enable > hold.
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_ifid.sv
// fetch_ifid: program counter, instruction fetch and IF/ID pipeline register
// feeding the main decoder of the pipelined LEGv8 core.
//   clk            rising-edge clock
//   reset          synchronous active-high reset (PC <= RESET_PC, IF/ID empty)
//   imem_addr      current PC, drives instruction memory (combinational read)
//   imem_rdata     instruction word at imem_addr
//   stall          hold PC, IF/ID and fetch_count (load-use hazard)
//   flush          taken branch: PC <= aligned branch_target, IF/ID <= bubble
//   branch_target  redirect address, used only when flush=1
//   ifid_instr     registered instruction word
//   ifid_pc        PC of ifid_instr
//   ifid_op        ifid_instr[31:21], decoder opcode input
//   ifid_valid     1 = real instruction, 0 = bubble
//   fetch_count    number of instructions captured into IF/ID (wraps)
// Priority per edge: reset > flush > stall > normal.
module fetch_ifid
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [N-1:0]  imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          flush,
  input  logic [N-1:0]  branch_target,
  output logic [31:0]   ifid_instr,
  output logic [N-1:0]  ifid_pc,
  output logic [10:0]   ifid_op,
  output logic          ifid_valid,
  output logic [31:0]   fetch_count
);

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_tgt;
  logic [31:0]  cnt_q, cnt_d;
  logic         pc_en, ifid_en, ifid_clr, cnt_en;

  // A flush always redirects, even under stall; a stall alone freezes
  // everything. Reset is handled inside each register.
  assign pc_tgt   = {branch_target[N-1:2], 2'b00};
  assign pc_en    = flush | ~stall;
  assign ifid_clr = flush;
  assign ifid_en  = ~stall;
  assign cnt_en   = ~stall & ~flush;

  // PC+4 wraps modulo 2^N by plain truncation.
  assign pc_d  = flush ? pc_tgt : pc_q + N'(PC_INCR);
  assign cnt_d = cnt_q + 32'd1;

  pipe_reg #(.W(N), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en_i(pc_en), .clr_i(1'b0),
    .d_i(pc_d), .q_o(pc_q)
  );

  pipe_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .en_i(ifid_en), .clr_i(ifid_clr),
    .d_i(imem_rdata), .q_o(ifid_instr)
  );

  pipe_reg #(.W(N), .RST_VAL('0)) u_ifpc (
    .clk(clk), .reset(reset), .en_i(ifid_en), .clr_i(ifid_clr),
    .d_i(pc_q), .q_o(ifid_pc)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .reset(reset), .en_i(ifid_en), .clr_i(ifid_clr),
    .d_i(1'b1), .q_o(ifid_valid)
  );

  pipe_reg #(.W(32), .RST_VAL(32'h0)) u_cnt (
    .clk(clk), .reset(reset), .en_i(cnt_en), .clr_i(1'b0),
    .d_i(cnt_d), .q_o(cnt_q)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = cnt_q;
  // Bubble word is all-zero, so the opcode of a bubble is zero too.
  assign ifid_op     = ifid_instr[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_ifid.sv
module tb_fetch_ifid;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [10:0] op;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, RESET_PC = 0
  logic        reset, stall, flush;
  logic [63:0] branch_target, imem_addr, ifid_pc;
  logic [31:0] imem_rdata, ifid_instr, fetch_count;
  logic [10:0] ifid_op;
  logic        ifid_valid;

  assign imem_rdata = 32'hF840_0000 + imem_addr[31:0];

  fetch_ifid #(.N(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .branch_target(branch_target),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_op(ifid_op),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count)
  );

  // second DUT for the PC wrap case
  logic        w_rst, w_stall, w_flush;
  logic [63:0] w_tgt, w_addr, w_pc;
  logic [31:0] w_rdata, w_instr, w_cnt;
  logic [10:0] w_op;
  logic        w_valid;

  assign w_rdata = 32'hF840_0000 + w_addr[31:0];

  fetch_ifid #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(w_stall), .flush(w_flush), .branch_target(w_tgt),
    .ifid_instr(w_instr), .ifid_pc(w_pc), .ifid_op(w_op),
    .ifid_valid(w_valid), .fetch_count(w_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb[$];
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle, push the reference expectation, pop and compare after the edge.
  task automatic step(input logic rst, input logic st, input logic fl, input logic [63:0] tgt);
    exp_t e;
    exp_t got;
    reset = rst; stall = st; flush = fl; branch_target = tgt;
    if (rst) begin
      m_pc = 64'h0; m_instr = 32'h0; m_ifpc = 64'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (fl) begin
      m_instr = 32'h0; m_ifpc = 64'h0; m_valid = 1'b0;
      m_pc = {tgt[63:2], 2'b00};
    end else if (!st) begin
      m_instr = 32'hF840_0000 + m_pc[31:0];
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc = m_ifpc;
    e.op = m_instr[31:21]; e.valid = m_valid; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_addr",  imem_addr,   got.addr);
    check("sb_instr", {32'h0, ifid_instr}, {32'h0, got.instr});
    check("sb_pc",    ifid_pc,     got.pc);
    check("sb_op",    {53'h0, ifid_op}, {53'h0, got.op});
    check("sb_valid", {63'h0, ifid_valid}, {63'h0, got.valid});
    check("sb_cnt",   {32'h0, fetch_count}, {32'h0, got.cnt});
  endtask

  initial begin
    logic [31:0] wexp;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    w_rst = 1'b1; w_stall = 1'b0; w_flush = 1'b0; w_tgt = '0;
    m_pc = '0; m_ifpc = '0; m_instr = '0; m_cnt = '0; m_valid = 1'b0;

    // reset held two cycles
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_valid", {63'h0, ifid_valid}, 64'h0);
    check("rst_op",    {53'h0, ifid_op}, 64'h0);

    // first fetch
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("f1_instr", {32'h0, ifid_instr}, 64'hF840_0000);
    check("f1_op",    {53'h0, ifid_op}, {53'h0, 11'b111_1100_0010});
    check("f1_addr",  imem_addr, 64'h4);
    check("f1_cnt",   {32'h0, fetch_count}, 64'd1);

    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("pre_stall_addr", imem_addr, 64'hC);

    // stall two cycles
    step(1'b0, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("stall_addr", imem_addr, 64'hC);
    check("stall_pc",   ifid_pc, 64'h8);
    check("stall_cnt",  {32'h0, fetch_count}, 64'd3);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("unstall_pc", ifid_pc, 64'hC);
    check("pre_flush_addr", imem_addr, 64'h10);

    // flush to misaligned target
    step(1'b0, 1'b0, 1'b1, 64'h103);
    check("flush_addr",  imem_addr, 64'h100);
    check("flush_instr", {32'h0, ifid_instr}, 64'h0);
    check("flush_valid", {63'h0, ifid_valid}, 64'h0);
    check("flush_cnt",   {32'h0, fetch_count}, 64'd4);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("post_flush_pc", ifid_pc, 64'h100);

    // flush and stall together
    step(1'b0, 1'b1, 1'b1, 64'h40);
    check("fs_addr",  imem_addr, 64'h40);
    check("fs_valid", {63'h0, ifid_valid}, 64'h0);
    check("fs_cnt",   {32'h0, fetch_count}, 64'd5);

    // reach 0x200 then reset together with flush and stall
    step(1'b0, 1'b0, 1'b1, 64'h1F8);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("pre_rst_addr", imem_addr, 64'h200);
    step(1'b1, 1'b1, 1'b1, 64'h80);
    check("mrst_addr",  imem_addr, 64'h0);
    check("mrst_instr", {32'h0, ifid_instr}, 64'h0);
    check("mrst_pc",    ifid_pc, 64'h0);
    check("mrst_cnt",   {32'h0, fetch_count}, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);

    // PC wrap on the second instance
    w_rst = 1'b0;
    @(posedge clk); #1;
    check("wrap_pc_after", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr",     w_addr, 64'h0);
    wexp = 32'hF840_0000 + 32'hFFFF_FFFC;
    check("wrap_instr",  {32'h0, w_instr}, {32'h0, wexp});
    check("wrap_op",     {53'h0, w_op}, {53'h0, wexp[31:21]});
    check("wrap_valid",  {63'h0, w_valid}, 64'h1);
    check("wrap_cnt",    {32'h0, w_cnt}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
